// File: rtl/sisc_alu_pkg.sv
// Shared definitions for the multi-cycle SISC ALU: function codes, FSM states
// and the bit positions inside the {C,V,N,Z} status word.
package sisc_alu_pkg;

    localparam logic [3:0] F_ADD  = 4'd1;
    localparam logic [3:0] F_SUB  = 4'd2;
    localparam logic [3:0] F_MUL  = 4'd3;
    localparam logic [3:0] F_NOT  = 4'd4;
    localparam logic [3:0] F_OR   = 4'd5;
    localparam logic [3:0] F_AND  = 4'd6;
    localparam logic [3:0] F_XOR  = 4'd7;
    localparam logic [3:0] F_ROTR = 4'd8;
    localparam logic [3:0] F_ROTL = 4'd9;
    localparam logic [3:0] F_SHR  = 4'd10;
    localparam logic [3:0] F_SHL  = 4'd11;

    localparam int ST_C = 3;
    localparam int ST_V = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Sequential shift-add multiplier: one partial product per step, WIDTH steps.
// 'product' is the accumulator value after the current step, so the parent can
// capture the final product on the same edge that performs the last step.
module mul_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Load latches operands and clears the accumulator; each step adds the
    // shifted multiplicand when the current multiplier LSB is set.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
        end else if (step && (cnt_q != '0)) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last    = (cnt_q == CNT_W'(1));
    assign product = acc_d;

endmodule

// File: rtl/sisc_alu_mc.sv
// Multi-cycle SISC ALU. Single-cycle ops register their result one edge after
// start; multiply runs WIDTH steps in mul_shift_add with busy held high.
module sisc_alu_mc
    import sisc_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rsa,
    input  logic [WIDTH-1:0] rsb,
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       stat,
    output logic             stat_en
);
    localparam int M    = WIDTH - 1;
    localparam int SH_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         stat_q, stat_d;
    logic               done_q, done_d;
    logic               sten_q, sten_d;
    logic               mul_sten_q, mul_sten_d;

    logic [3:0]         funct;
    logic               is_imm, is_mul, do_sub;
    logic [WIDTH-1:0]   imm_sx, add_b;
    logic [WIDTH:0]     sum;
    logic               add_c, add_v;
    logic [SH_W-1:0]    rot_amt;
    logic [2*WIDTH-1:0] rotr_w, rotl_w;
    logic [WIDTH-1:0]   sc_res;
    logic [3:0]         sc_stat;

    logic               mul_load, mul_step, mul_last;
    logic [2*WIDTH-1:0] mul_prod;
    logic [3:0]         mul_stat;

    assign funct   = imm[3:0];
    assign is_imm  = alu_op[0];
    assign is_mul  = (funct == F_MUL) && !is_imm;
    assign do_sub  = (funct == F_SUB) && !is_imm;
    assign imm_sx  = WIDTH'($signed(imm));
    assign add_b   = is_imm ? imm_sx : rsb;
    assign rot_amt = rsb[SH_W-1:0];
    assign rotr_w  = {rsa, rsa} >> rot_amt;
    assign rotl_w  = {rsa, rsa} << rot_amt;

    // Shared WIDTH+1 adder; its C/V also feed the status of logic/shift ops.
    always_comb begin
        sum   = do_sub ? ({1'b0, rsa} - {1'b0, add_b}) : ({1'b0, rsa} + {1'b0, add_b});
        add_c = sum[WIDTH];
        add_v = do_sub ? ((rsa[M] != add_b[M]) && (sum[M] != rsa[M]))
                       : ((rsa[M] == add_b[M]) && (sum[M] != rsa[M]));
    end

    // Single-cycle result mux; immediate mode always takes the adder.
    always_comb begin
        sc_res = '0;
        if (is_imm) begin
            sc_res = sum[M:0];
        end else begin
            case (funct)
                F_ADD, F_SUB: sc_res = sum[M:0];
                F_NOT:        sc_res = ~rsa;
                F_OR:         sc_res = rsa | rsb;
                F_AND:        sc_res = rsa & rsb;
                F_XOR:        sc_res = rsa ^ rsb;
                F_ROTR:       sc_res = rotr_w[WIDTH-1:0];
                F_ROTL:       sc_res = rotl_w[2*WIDTH-1:WIDTH];
                F_SHR:        sc_res = rsa >> rsb;
                F_SHL:        sc_res = rsa << rsb;
                default:      sc_res = '0;
            endcase
        end
        sc_stat       = '0;
        sc_stat[ST_C] = add_c;
        sc_stat[ST_V] = add_v;
        sc_stat[ST_N] = sc_res[M];
        sc_stat[ST_Z] = (sc_res == '0);
    end

    // Multiply status: carry flags a non-zero upper half, overflow never set.
    always_comb begin
        mul_stat       = '0;
        mul_stat[ST_C] = |mul_prod[2*WIDTH-1:WIDTH];
        mul_stat[ST_N] = mul_prod[M];
        mul_stat[ST_Z] = (mul_prod[M:0] == '0);
    end

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .load     (mul_load),
        .step     (mul_step),
        .mcand_i  (rsa),
        .mplier_i (rsb),
        .last     (mul_last),
        .product  (mul_prod)
    );

    // FSM next state and output register inputs; start is ignored while in MUL.
    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        stat_d     = stat_q;
        done_d     = 1'b0;
        sten_d     = 1'b0;
        mul_sten_d = mul_sten_q;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        mul_load   = 1'b1;
                        mul_sten_d = !alu_op[1];
                        state_d    = MUL;
                    end else begin
                        res_d  = sc_res;
                        stat_d = sc_stat;
                        done_d = 1'b1;
                        sten_d = !alu_op[1] && !is_imm && ((funct == F_ADD) || (funct == F_SUB));
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    res_d   = mul_prod[M:0];
                    stat_d  = mul_stat;
                    done_d  = 1'b1;
                    sten_d  = mul_sten_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            res_q      <= '0;
            stat_q     <= '0;
            done_q     <= 1'b0;
            sten_q     <= 1'b0;
            mul_sten_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            stat_q     <= stat_d;
            done_q     <= done_d;
            sten_q     <= sten_d;
            mul_sten_q <= mul_sten_d;
        end
    end

    assign busy       = (state_q == MUL);
    assign done       = done_q;
    assign alu_result = res_q;
    assign stat       = stat_q;
    assign stat_en    = sten_q;

endmodule

// File: tb/tb_sisc_alu_mc.sv
// Scoreboard bench: stimulus pushes expected {result,stat,stat_en}; a negedge
// monitor pops and compares whenever a DUT raises done.
module tb_sisc_alu_mc;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
        logic        en;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // 32-bit instance
    logic        st32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [15:0] imm32 = '0;
    logic [1:0]  op32 = '0;
    logic        busy32, done32, sten32;
    logic [31:0] res32;
    logic [3:0]  stat32;

    // 8-bit instance
    logic        st8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, imm8 = '0;
    logic [1:0]  op8 = '0;
    logic        busy8, done8, sten8;
    logic [7:0]  res8;
    logic [3:0]  stat8;

    exp_t q32[$];
    exp_t q8[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sisc_alu_mc #(.WIDTH(32), .IMM_W(16)) u32 (
        .clk(clk), .rst(rst), .start(st32), .rsa(a32), .rsb(b32), .imm(imm32),
        .alu_op(op32), .busy(busy32), .done(done32), .alu_result(res32),
        .stat(stat32), .stat_en(sten32)
    );

    sisc_alu_mc #(.WIDTH(8), .IMM_W(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .rsa(a8), .rsb(b8), .imm(imm8),
        .alu_op(op8), .busy(busy8), .done(done8), .alu_result(res8),
        .stat(stat8), .stat_en(sten8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every done pulse against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (done32) begin
                if (q32.size() == 0) begin
                    chk("unexpected_done32", 1, 0);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    chk("res32", {27'd0, sten32, stat32, res32}, {27'd0, e.en, e.st, e.res});
                end
            end else if (sten32) begin
                chk("sten_without_done32", 1, 0);
            end
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_done8", 1, 0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("res8", {51'd0, sten8, stat8, res8}, {51'd0, e.en, e.st, e.res[7:0]});
                end
            end else if (sten8) begin
                chk("sten_without_done8", 1, 0);
            end
        end
    end

    // Drive one op on the 32-bit DUT and advance to the next negedge.
    task automatic iss32(input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                         input logic [1:0] op, input logic [31:0] er, input logic [3:0] es,
                         input logic ee, input bit lat1);
        exp_t e;
        a32 = a; b32 = b; imm32 = im; op32 = op; st32 = 1'b1;
        e.res = er; e.st = es; e.en = ee;
        q32.push_back(e);
        @(negedge clk);
        if (lat1) chk("latency1_done32", {63'd0, done32}, 64'd1);
    endtask

    task automatic iss8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] im,
                        input logic [1:0] op, input logic [7:0] er, input logic [3:0] es,
                        input logic ee, input bit lat1);
        exp_t e;
        a8 = a; b8 = b; imm8 = im; op8 = op; st8 = 1'b1;
        e.res = {24'd0, er}; e.st = es; e.en = ee;
        q8.push_back(e);
        @(negedge clk);
        if (lat1) chk("latency1_done8", {63'd0, done8}, 64'd1);
    endtask

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("reset32", {27'd0, busy32, done32, sten32, stat32, res32}, 64'd0);
        chk("reset8",  {51'd0, busy8, done8, sten8, stat8, res8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Signed overflow add
        iss32(32'h7FFF_FFFF, 32'h1, 16'h0001, 2'b00, 32'h8000_0000, 4'b0110, 1'b1, 1'b1);
        st32 = 1'b0;

        // Async reset mid-cycle clears outputs immediately
        #2 rst = 1'b1;
        #1 chk("async_reset32", {27'd0, busy32, done32, sten32, stat32, res32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle ops back to back
        iss32(32'd5, 32'd5, 16'h0002, 2'b00, 32'd0, 4'b0001, 1'b1, 1'b1);           // sub 5-5
        iss32(32'd3, 32'd7, 16'hFFFF, 2'b01, 32'd2, 4'b1000, 1'b0, 1'b1);           // rsa + sext(-1)
        iss32(32'd1, 32'd2, 16'h0001, 2'b10, 32'd3, 4'b0000, 1'b0, 1'b1);           // add, stat_en masked
        iss32(32'd3, 32'd5, 16'h0002, 2'b00, 32'hFFFF_FFFE, 4'b1010, 1'b1, 1'b1);   // sub with borrow
        iss32(32'd0, 32'd0, 16'h0004, 2'b00, 32'hFFFF_FFFF, 4'b0010, 1'b0, 1'b1);   // not
        iss32(32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0005, 2'b00, 32'hFFF0_FFF0, 4'b1010, 1'b0, 1'b1);
        iss32(32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0006, 2'b00, 32'h00F0_00F0, 4'b1000, 1'b0, 1'b1);
        iss32(32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0007, 2'b00, 32'hFF00_FF00, 4'b1010, 1'b0, 1'b1);
        iss32(32'hFFFF_FFFF, 32'd32, 16'h000A, 2'b00, 32'd0, 4'b1001, 1'b0, 1'b1);  // shr by WIDTH
        iss32(32'd1, 32'd31, 16'h000B, 2'b00, 32'h8000_0000, 4'b0010, 1'b0, 1'b1);  // shl by 31
        iss32(32'd1, 32'd1, 16'h0000, 2'b00, 32'd0, 4'b0001, 1'b0, 1'b1);           // funct 0
        st32 = 1'b0;
        @(negedge clk);

        // Multiply with an ignored start while busy
        iss32(32'hFFFF_FFFF, 32'd2, 16'h0003, 2'b00, 32'hFFFF_FFFE, 4'b1010, 1'b1, 1'b0);
        st32 = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            chk("mul_busy", {62'd0, busy32, done32}, 64'b10);
            if (i == 5) begin
                a32 = 32'd9; b32 = 32'd9; imm32 = 16'h0001; st32 = 1'b1;
            end
            if (i == 6) st32 = 1'b0;
            @(negedge clk);
        end
        chk("mul_done_cycle", {62'd0, busy32, done32}, 64'b01);
        // New op accepted in the done cycle
        iss32(32'd2, 32'd3, 16'h0001, 2'b00, 32'd5, 4'b0000, 1'b1, 1'b1);
        st32 = 1'b0;
        @(negedge clk);

        // Reset during multiply aborts it
        iss32(32'd3, 32'd4, 16'h0003, 2'b00, 32'd12, 4'b0000, 1'b1, 1'b0);
        st32 = 1'b0;
        repeat (9) @(negedge clk);
        chk("mul_busy_c10", {63'd0, busy32}, 64'd1);
        #2 rst = 1'b1;
        q32.delete();
        #1 chk("abort_reset32", {27'd0, busy32, done32, sten32, stat32, res32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done32) chk("done_after_abort", 1, 0);
            @(negedge clk);
        end
        chk("no_done_after_abort", {63'd0, done32}, 64'd0);
        iss32(32'd1, 32'd1, 16'h0001, 2'b00, 32'd2, 4'b0000, 1'b1, 1'b1);
        st32 = 1'b0;
        @(negedge clk);

        // 8-bit shifts, rotates and unused codes
        iss8(8'h81, 8'd9, 8'h09, 2'b00, 8'h03, 4'b0000, 1'b0, 1'b1);   // rotl by 9 -> 1
        iss8(8'h80, 8'd8, 8'h0A, 2'b00, 8'h00, 4'b0001, 1'b0, 1'b1);   // shr by WIDTH
        iss8(8'h10, 8'h20, 8'h0D, 2'b00, 8'h00, 4'b0001, 1'b0, 1'b1);  // funct 13
        iss8(8'h81, 8'd1, 8'h08, 2'b00, 8'hC0, 4'b0010, 1'b0, 1'b1);   // rotr by 1
        iss8(8'h81, 8'd1, 8'h0B, 2'b00, 8'h02, 4'b0000, 1'b0, 1'b1);   // shl by 1
        iss8(8'h03, 8'd7, 8'h0B, 2'b00, 8'h80, 4'b0010, 1'b0, 1'b1);   // shl by 7
        st8 = 1'b0;
        @(negedge clk);

        // 8-bit multiply overflowing into the upper half
        iss8(8'h10, 8'h10, 8'h03, 2'b00, 8'h00, 4'b1001, 1'b1, 1'b0);
        st8 = 1'b0;
        repeat (8) @(negedge clk);
        chk("mul8_done", {62'd0, busy8, done8}, 64'b01);
        @(negedge clk);

        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained",  64'(q8.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sisc_alu_mc.md
# sisc_alu_mc

Parametrised, multi-cycle successor to the SISC single-cycle ALU. It keeps the existing function-code map, status-bit semantics and immediate handling, generalised to `WIDTH`-bit datapaths. It adds a start/done handshake and a sequential shift-add multiplier (funct 3). It sits between the register file and the writeback/status-register path, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: datapath width; must be ≥ 8 and a power of two.
- `IMM_W`, default 16: immediate width; must be ≤ `WIDTH`; sign-extended to `WIDTH`.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: operation request; sampled only when `busy`=0.
- `rsa` input, `WIDTH` bits: operand A (Rs).
- `rsb` input, `WIDTH` bits: operand B (Rt); also the shift/rotate amount.
- `imm` input, `IMM_W` bits: immediate; `imm[3:0]` is the function code.
- `alu_op` input, 2 bits:
  - bit0 = 1 selects sign-extended imm as the adder B operand and forces an add.
  - bit1 = 1 suppresses `stat_en`.
- `busy` output, 1 bit: multiply in progress.
- `done` output, 1 bit: one-cycle pulse when `alu_result`/`stat` update.
- `alu_result` output, `WIDTH` bits: registered result; holds its value until the next `done`.
- `stat` output, 4 bits: {C,V,N,Z}, registered; updates with `done`.
- `stat_en` output, 1 bit: one-cycle pulse coincident with `done`, for qualifying ops only.

## Operation
- Function codes:
  - 1 add, 2 sub, 3 mul
  - 4 not A, 5 or, 6 and, 7 xor
  - 8 rotr, 9 rotl, 10 shr (logical), 11 shl
  - 0 and 12–15 produce result 0.
- `alu_op[0]`=1: the result is always `rsa + sext(imm)`, whatever funct says. Sub-immediate is not supported.
- Shifts: amount is the full `rsb`; amount ≥ `WIDTH` yields 0.
- Rotates: amount is `rsb mod WIDTH`.
- Adder is `WIDTH+1` bits wide. For add/sub:
  - C = bit `WIDTH` of the adder output (carry, or borrow for sub).
  - V = signed overflow of the operation performed, using the `fsb` formula generalised to MSB `WIDTH-1`.
- Mul: unsigned `rsa*rsb`; `alu_result` = low `WIDTH` bits.
  - C = 1 if the high `WIDTH` bits are non-zero.
  - V = 0.
- For all ops: N = `alu_result[WIDTH-1]`; Z = (`alu_result` == 0).
- For non-adder ops, C and V are the adder outputs for the same operands, matching the existing block.
- `stat_en` = `done` & (funct ∈ {1,2,3}) & `alu_op[1]`==0 & `alu_op[0]`==0.
- FSM states:
  - IDLE
    - `start` with mul (funct 3, `alu_op[0]`=0) → MUL: latch operands, clear accumulator, counter = `WIDTH`.
    - `start` with any other op: compute and register in the same edge, pulse `done`, stay in IDLE.
  - MUL
    - Each cycle: if multiplier LSB is set, accumulator += multiplicand.
    - Shift multiplicand left and multiplier right; decrement counter.
    - On the edge where the counter reaches 0: register the result and stat, pulse `done`, go to IDLE.
- `start` while `busy`: ignored, no queueing. Operand changes during MUL have no effect because operands are latched.

## Timing
- Reset values:
  - `alu_result`=0, `stat`=0, `done`=0, `stat_en`=0, `busy`=0.
  - FSM = IDLE, counter = 0.
- Single-cycle ops: `start` sampled at edge k → result and `done` valid in cycle k+1 (latency 1, same as the existing registered ALU).
- Mul: `start` at edge k → `busy`=1 from cycle k+1 to cycle k+`WIDTH`; `done` valid in cycle k+`WIDTH`+1, with `busy`=0 in that cycle.
- Back-to-back ops:
  - A new `start` is accepted in the cycle `done` is high, because `busy`=0 then.
  - Single-cycle ops can issue every cycle, giving `done` every cycle.
- Reset asserted mid-MUL aborts the operation: no `done` is generated, outputs return to reset values, FSM returns to IDLE.

## Structure
- Package `sisc_alu_pkg`:
  - function-code localparams (`F_ADD` … `F_SHL`)
  - FSM state typedef {IDLE, MUL}
  - status bit indices C=3, V=2, N=1, Z=0
- One sub-module, `mul_shift_add`:
  - holds the multiplicand, multiplier and `2*WIDTH` accumulator registers, plus the step counter
  - ports: load, step, last, product
  - the parent FSM and single-cycle datapath instantiate it.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately.
- WIDTH=32, add 0x7FFFFFFF+1 → result 0x80000000, stat {C0,V1,N1,Z0}, `stat_en`=1 one cycle after `start`.
- Sub 5−5 → result 0, stat {C0,V0,N0,Z1}. Then `alu_op`=2'b01, imm=0xFFFF, rsa=3 → result 2, `stat_en`=0.
- Mul 0xFFFFFFFF*2 → `busy`=1 for 32 cycles, `done` at start+33, result 0xFFFFFFFE, C=1. A `start` asserted while `busy` is ignored.
- Shifts and rotates at WIDTH=8:
  - rotl 0x81 by 9 → 0x03
  - shr 0x80 by 8 → 0x00
  - funct 13 → 0x00 with Z=1.
- Assert `rst` at cycle 10 of a mul → no `done` pulse; a following add completes normally with latency 1.
